// File: rtl/dmem_responder.sv
// RV64 MEM-stage data memory responder: byte-lane steering, load extension,
// alignment/range checks and configurable wait states behind a stall handshake.
module dmem_responder #(
    parameter int DATA_WIDTH  = 64,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  req_we,
    input  logic                  req_re,
    input  logic [2:0]            req_func3,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  stall,
    output logic                  err
);
    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam int         AW        = DEPTH_LOG2 + 3;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_cnt;
    logic [AW-1:0]         r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_we;
    logic [2:0]            r_func3;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_valid, w_reject, w_accept, w_misal, w_oor, w_illegal;
    logic                  w_fire;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [5:0]            w_shift;
    logic [DATA_WIDTH-1:0] w_word, w_wmask, w_wdata_sh, w_merged, w_load;

    function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [1:0] size);
        case (size)
            2'b00:   lane_mask = 64'h0000_0000_0000_00FF;
            2'b01:   lane_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   lane_mask = 64'h0000_0000_FFFF_FFFF;
            default: lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    // v already has the addressed lane shifted down to bit 0
    function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [DATA_WIDTH-1:0] v,
                                                          input logic [2:0] f3);
        case (f3)
            3'b000:  load_extend = {{56{v[7]}}, v[7:0]};
            3'b100:  load_extend = {56'd0, v[7:0]};
            3'b001:  load_extend = {{48{v[15]}}, v[15:0]};
            3'b101:  load_extend = {48'd0, v[15:0]};
            3'b010:  load_extend = {{32{v[31]}}, v[31:0]};
            3'b110:  load_extend = {32'd0, v[31:0]};
            default: load_extend = v;
        endcase
    endfunction

    always_comb begin
        w_misal = 1'b0;
        case (req_func3[1:0])
            2'b01:   w_misal = req_addr[0];
            2'b10:   w_misal = |req_addr[1:0];
            2'b11:   w_misal = |req_addr[2:0];
            default: w_misal = 1'b0;
        endcase
    end

    assign w_valid   = req_re | req_we;
    assign w_oor     = |req_addr[DATA_WIDTH-1:AW];
    assign w_illegal = (req_re && req_func3 == 3'b111) || (req_we && req_func3[2]);
    assign w_reject  = w_valid && ((req_re && req_we) || w_misal || w_oor || w_illegal);
    assign w_accept  = w_valid && !w_reject;

    always_comb begin
        w_state_next = r_state;
        stall        = 1'b0;
        w_fire       = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall = w_accept;
                if (w_accept) w_state_next = S_ACCESS;
            end
            S_ACCESS: begin
                stall = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_fire       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_idx      = r_addr[AW-1:3];
    assign w_shift    = {r_addr[2:0], 3'b000};
    assign w_word     = r_mem[w_idx];
    assign w_wmask    = lane_mask(r_func3[1:0]) << w_shift;
    assign w_wdata_sh = (r_wdata & lane_mask(r_func3[1:0])) << w_shift;
    assign w_merged   = (w_word & ~w_wmask) | w_wdata_sh;
    assign w_load     = load_extend(w_word >> w_shift, r_func3);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_err   <= (r_state == S_IDLE) && w_reject;
            if (r_state == S_IDLE && w_accept)
                r_cnt <= WAIT_INIT;
            else if (r_state == S_ACCESS && r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
            if (w_fire && !r_we)
                r_rdata <= w_load;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_accept) begin
            r_addr  <= req_addr[AW-1:0];
            r_wdata <= req_wdata;
            r_we    <= req_we;
            r_func3 <= req_func3;
        end
    end

    // Gated by rst_n so a reset landing on the access edge aborts the write
    always_ff @(posedge clk) begin
        if (rst_n && w_fire && r_we)
            r_mem[w_idx] <= w_merged;
    end

    assign rdata = r_rdata;
    assign err   = r_err;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (0 and 3 wait states) driven by directed
// and random traffic, checked against a byte-array memory model.
module tb_dmem_responder;
    logic        clk;
    logic        rst_n [2];
    logic [63:0] addr  [2];
    logic [63:0] wdata [2];
    logic        we    [2];
    logic        re    [2];
    logic [2:0]  f3    [2];
    logic [63:0] rdata [2];
    logic        stall [2];
    logic        err   [2];

    logic [7:0]  mb  [2][8192];
    logic [63:0] mrd [2];
    int          n_chk;
    int          n_fail;
    logic [63:0] got;

    dmem_responder #(.DATA_WIDTH(64), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .req_addr(addr[0]), .req_wdata(wdata[0]),
        .req_we(we[0]), .req_re(re[0]), .req_func3(f3[0]),
        .rdata(rdata[0]), .stall(stall[0]), .err(err[0]));

    dmem_responder #(.DATA_WIDTH(64), .DEPTH_LOG2(10), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n[1]), .req_addr(addr[1]), .req_wdata(wdata[1]),
        .req_we(we[1]), .req_re(re[1]), .req_func3(f3[1]),
        .rdata(rdata[1]), .stall(stall[1]), .err(err[1]));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic bit m_reject(input bit r, input bit w, input logic [2:0] f,
                                    input logic [63:0] a);
        longint unsigned sz;
        sz = 64'd1 << f[1:0];
        if (r && w) return 1'b1;
        if (w && f[2]) return 1'b1;
        if (r && f == 3'b111) return 1'b1;
        if (a >= 64'd8192) return 1'b1;
        if ((a % sz) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [63:0] m_load(input int d, input logic [63:0] a, input logic [2:0] f);
        int          n;
        logic [63:0] v;
        n = 1 << f[1:0];
        v = 64'd0;
        for (int i = 0; i < n; i++)
            v = v | (64'(mb[d][int'(a) + i]) << (8 * i));
        if (!f[2] && n < 8 && v[8 * n - 1])
            v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input bit r, input bit w, input logic [2:0] f,
                         input logic [63:0] a, input logic [63:0] wd);
        re[d]    = r;
        we[d]    = w;
        f3[d]    = f;
        addr[d]  = a;
        wdata[d] = wd;
    endtask

    task automatic idle(input int d);
        drive(d, 1'b0, 1'b0, 3'b000, 64'd0, 64'd0);
    endtask

    // One request from the requester's side; ends in the DONE (or post-reject) cycle
    task automatic access(input int d, input bit r, input bit w, input logic [2:0] f,
                          input logic [63:0] a, input logic [63:0] wd,
                          input bit keep, output logic [63:0] obs);
        int hi;
        cyc();
        drive(d, r, w, f, a, wd);
        #1;
        obs = rdata[d];
        if (m_reject(r, w, f, a)) begin
            chk("rej_stall", 64'(stall[d]), 64'd0);
            cyc();
            idle(d);
            #1;
            chk("rej_err", 64'(err[d]), 64'd1);
            chk("rej_rdata", rdata[d], mrd[d]);
            cyc();
            #1;
            chk("rej_err_clr", 64'(err[d]), 64'd0);
            return;
        end
        chk("acc_stall", 64'(stall[d]), 64'd1);
        hi = 1;
        for (int k = 0; k < 40; k++) begin
            cyc();
            #1;
            if (!stall[d]) break;
            hi++;
        end
        chk("stall_cycles", 64'(hi), 64'(wait_of(d) + 2));
        chk("done_err", 64'(err[d]), 64'd0);
        if (w) begin
            for (int i = 0; i < (1 << f[1:0]); i++)
                mb[d][int'(a) + i] = wd[8 * i +: 8];
        end else begin
            mrd[d] = m_load(d, a, f);
        end
        chk(w ? "done_rdata_hold" : "load_data", rdata[d], mrd[d]);
        obs = rdata[d];
        if (!keep) idle(d);
    endtask

    initial begin
        logic [63:0] a;
        logic [2:0]  f;
        int          sel, op;
        clk    = 1'b0;
        n_chk  = 0;
        n_fail = 0;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0;
            mrd[d]   = 64'd0;
            idle(d);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_rdata", rdata[d], 64'd0);
            chk("reset_stall", 64'(stall[d]), 64'd0);
            chk("reset_err", 64'(err[d]), 64'd0);
        end

        // zero-wait instance: lane steering and extension
        access(0, 0, 1, 3'b011, 64'h10, 64'h8877665544332211, 0, got);
        access(0, 1, 0, 3'b011, 64'h10, 64'd0, 0, got);
        chk("ld_10", got, 64'h8877665544332211);
        access(0, 1, 0, 3'b000, 64'h17, 64'd0, 0, got);
        chk("lb_17", got, 64'hFFFFFFFFFFFFFF88);
        access(0, 1, 0, 3'b100, 64'h17, 64'd0, 0, got);
        chk("lbu_17", got, 64'h0000000000000088);
        access(0, 1, 0, 3'b001, 64'h16, 64'd0, 0, got);
        chk("lh_16", got, 64'hFFFFFFFFFFFF8877);
        access(0, 1, 0, 3'b110, 64'h14, 64'd0, 0, got);
        chk("lwu_14", got, 64'h0000000088776655);
        access(0, 0, 1, 3'b000, 64'h11, 64'hAB, 0, got);
        access(0, 1, 0, 3'b011, 64'h10, 64'd0, 0, got);
        chk("sb_merge", got, 64'h887766554433AB11);

        access(0, 1, 0, 3'b010, 64'h12, 64'd0, 0, got);
        access(0, 1, 1, 3'b011, 64'h10, 64'd0, 0, got);
        access(0, 1, 0, 3'b011, 64'h4000, 64'd0, 0, got);
        access(0, 1, 0, 3'b011, 64'h2000, 64'd0, 0, got);
        chk("rej_hold", rdata[0], 64'h887766554433AB11);
        access(0, 0, 1, 3'b011, 64'h1FF8, 64'h0102030405060708, 0, got);
        access(0, 0, 1, 3'b000, 64'h1FFF, 64'hC3, 0, got);
        access(0, 1, 0, 3'b011, 64'h1FF8, 64'd0, 0, got);
        chk("ld_top", got, 64'hC302030405060708);

        // three-wait instance: latency, back-to-back, reset abort
        access(1, 0, 1, 3'b011, 64'h20, 64'h0123456789ABCDEF, 0, got);
        access(1, 1, 0, 3'b011, 64'h20, 64'd0, 1, got);
        chk("ld_20_w3", got, 64'h0123456789ABCDEF);
        drive(1, 1'b1, 1'b0, 3'b010, 64'h24, 64'd0);
        #1;
        chk("b2b_done_stall", 64'(stall[1]), 64'd0);
        access(1, 1, 0, 3'b010, 64'h24, 64'd0, 0, got);
        chk("b2b_lw_24", got, 64'h0000000001234567);

        cyc();
        drive(1, 1'b0, 1'b1, 3'b011, 64'h20, 64'hFFFFFFFFFFFFFFFF);
        #1;
        chk("abort_req_stall", 64'(stall[1]), 64'd1);
        cyc();
        cyc();
        rst_n[1] = 1'b0;
        cyc();
        rst_n[1] = 1'b1;
        idle(1);
        #1;
        mrd[1] = 64'd0;
        chk("abort_stall", 64'(stall[1]), 64'd0);
        chk("abort_rdata", rdata[1], 64'd0);
        chk("abort_err", 64'(err[1]), 64'd0);
        access(1, 1, 0, 3'b011, 64'h20, 64'd0, 0, got);
        chk("abort_no_write", got, 64'h0123456789ABCDEF);

        // random traffic over an initialised region plus the top word
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 16; w++)
                access(d, 0, 1, 3'b011, 64'(w * 8), {$urandom, $urandom}, 0, got);
            access(d, 0, 1, 3'b011, 64'h1FF8, {$urandom, $urandom}, 0, got);
            for (int n = 0; n < 120; n++) begin
                sel = $urandom_range(0, 9);
                if (sel < 7)       a = 64'($urandom_range(0, 127));
                else if (sel == 7) a = 64'h1FF8 + 64'($urandom_range(0, 7));
                else if (sel == 8) a = 64'h2000 + 64'($urandom_range(0, 255));
                else               a = {$urandom | 32'h1, $urandom};
                f  = 3'($urandom_range(0, 7));
                op = $urandom_range(0, 9);
                access(d, op < 5 || op == 9, op >= 5, f, a, {$urandom, $urandom}, 0, got);
                if ($urandom_range(0, 3) == 0) cyc();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
